// File: rtl/spi_flash_rd.sv
// SPI flash read sequencer: sends CMD + 24-bit address, then one DUMMY per data byte, through a byte-wide spi_phy.
// Latency: start is accepted in IDLE; each byte costs one SEND, a WAIT until phy o_rdy, then one DROP/DELIVER cycle.
// Backpressure: o_wr waits for i_bsy low; DELIVER holds o_valid/o_data stable until i_ready, and no new byte is sent meanwhile.
module spi_flash_rd #(
    parameter logic [7:0] CMD   = 8'h03,
    parameter logic [7:0] DUMMY = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_addr,
    input  logic [7:0]  i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_wr,
    output logic [7:0]  o_wdata,
    input  logic        i_bsy,
    output logic        o_rd,
    input  logic [7:0]  i_rdata,
    input  logic        i_rdy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DROP,
        S_DELIVER
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] addr_q,  addr_d;
    // Remaining data bytes still to deliver.
    logic [7:0]  len_q,   len_d;
    // Byte index: 0..3 are header bytes, 4 marks the data phase (saturates there).
    logic [2:0]  idx_q,   idx_d;
    logic [7:0]  cur_byte;

    // Byte to transmit for the current index.
    always_comb begin
        cur_byte = DUMMY;
        case (idx_q)
            3'd0:    cur_byte = CMD;
            3'd1:    cur_byte = addr_q[23:16];
            3'd2:    cur_byte = addr_q[15:8];
            3'd3:    cur_byte = addr_q[7:0];
            default: cur_byte = DUMMY;
        endcase
    end

    // Next-state and output decode; all strobes are combinational from state and phy handshakes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        o_wr    = 1'b0;
        o_wdata = 8'h00;
        o_rd    = 1'b0;
        o_done  = 1'b0;
        o_valid = 1'b0;
        o_data  = 8'h00;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d  = i_addr;
                    len_d   = i_len;
                    idx_d   = 3'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                o_wdata = cur_byte;
                if (!i_bsy) begin
                    o_wr    = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_rdy) begin
                    state_d = (idx_q < 3'd4) ? S_DROP : S_DELIVER;
                end
            end
            S_DROP: begin
                o_rd = 1'b1;
                if (idx_q == 3'd3 && len_q == 8'd0) begin
                    o_done  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_SEND;
                end
            end
            S_DELIVER: begin
                o_valid = 1'b1;
                o_data  = i_rdata;
                if (i_ready) begin
                    o_rd  = 1'b1;
                    len_d = len_q - 8'd1;
                    if (len_q == 8'd1) begin
                        o_done  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy = (state_q != S_IDLE);

    // State and transaction registers; reset wins over any pending start.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= 24'h000000;
            len_q   <= 8'h00;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_rd.sv
// Bench for spi_flash_rd: a behavioural spi_phy plus flash image drives the DUT.
// The expected byte stream and delivered data are built from the transaction parameters.
// Directed corner cases first, then randomized addresses, lengths, phy latency and consumer stalls.
module tb_spi_flash_rd;

    localparam logic [7:0] CMD   = 8'h03;
    localparam logic [7:0] DUMMY = 8'h00;

    logic        i_clk = 1'b0;
    logic        i_rst, i_start, i_ready, i_bsy, i_rdy;
    logic [23:0] i_addr;
    logic [7:0]  i_len, i_rdata;
    logic        o_busy, o_done, o_valid, o_wr, o_rd;
    logic [7:0]  o_data, o_wdata;

    always #5 i_clk = ~i_clk;

    spi_flash_rd #(.CMD(CMD), .DUMMY(DUMMY)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_addr  (i_addr),
        .i_len   (i_len),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_wr    (o_wr),
        .o_wdata (o_wdata),
        .i_bsy   (i_bsy),
        .o_rd    (o_rd),
        .i_rdata (i_rdata),
        .i_rdy   (i_rdy)
    );

    int total = 0;
    int bad   = 0;

    // Expected writes and expected delivered bytes for the running transaction.
    logic [7:0] exp_wq[$];
    logic [7:0] exp_dq[$];
    int wr_cnt, rd_cnt, dlv_cnt, done_cnt, stall_cnt;

    // Environment knobs.
    logic [23:0] cur_addr;
    bit  loop_mode, rand_ready, force_on, prev_hold;
    int  ready_hold, force_cnt;
    logic [7:0] prev_data;

    // Phy model: 0 idle, 1 shifting, 2 byte ready.
    int ph_state, ph_cnt, byte_no;
    logic [7:0] ph_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    // One clock: observe outputs on the falling edge, then update the phy and consumer after the rising edge.
    task automatic step();
        logic s_wr, s_rd, s_valid, s_done, s_rst;
        logic [7:0] s_wdata;
        @(negedge i_clk);
        s_wr = o_wr; s_rd = o_rd; s_valid = o_valid; s_done = o_done;
        s_rst = i_rst; s_wdata = o_wdata;
        if (prev_hold) begin
            chk("hold_valid", {31'd0, o_valid}, 32'd1);
            chk("hold_data", {24'd0, o_data}, {24'd0, prev_data});
        end
        if (force_on) chk("wr_while_bsy", {31'd0, o_wr}, 32'd0);
        if (o_wr || o_rd) chk("wr_rd_excl", {31'd0, o_wr & o_rd}, 32'd0);
        if (o_valid) chk("valid_busy", {31'd0, o_busy}, 32'd1);
        if (o_wr) begin
            wr_cnt++;
            if (exp_wq.size() > 0) chk("wdata", {24'd0, o_wdata}, {24'd0, exp_wq.pop_front()});
            else chk("extra_wr", {31'd0, o_wr}, 32'd0);
        end
        if (o_valid && i_ready) begin
            dlv_cnt++;
            if (exp_dq.size() > 0) chk("rdata", {24'd0, o_data}, {24'd0, exp_dq.pop_front()});
            else chk("extra_dlv", {31'd0, o_valid}, 32'd0);
        end
        if (o_valid && !i_ready) begin
            stall_cnt++;
            chk("rd_in_stall", {31'd0, o_rd}, 32'd0);
            chk("wr_in_stall", {31'd0, o_wr}, 32'd0);
        end
        if (o_rd) rd_cnt++;
        if (o_done) done_cnt++;
        prev_hold = o_valid && !i_ready && !i_rst;
        prev_data = o_data;

        @(posedge i_clk);
        #1;
        if (s_rst) begin
            ph_state = 0;
            byte_no  = 0;
        end else begin
            case (ph_state)
                0: if (s_wr) begin
                    ph_state = 1;
                    ph_cnt   = $urandom_range(1, 4);
                    if (loop_mode)       ph_data = ~s_wdata;
                    else if (byte_no >= 4) ph_data = flash_byte(cur_addr + 24'(byte_no - 4));
                    else                 ph_data = 8'($urandom);
                    byte_no++;
                end
                1: begin
                    ph_cnt--;
                    if (ph_cnt == 0) ph_state = 2;
                end
                default: if (s_rd) ph_state = 0;
            endcase
            if (s_done) byte_no = 0;
        end
        force_on = (force_cnt > 0);
        if (force_cnt > 0) force_cnt--;
        i_bsy   = (ph_state != 0) || force_on;
        i_rdy   = (ph_state == 2);
        i_rdata = ph_data;
        if (ready_hold > 0 && s_valid) ready_hold--;
        if (ready_hold > 0)  i_ready = 1'b0;
        else if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        else                 i_ready = 1'b1;
    endtask

    task automatic check_idle_outputs();
        chk("rst_busy",  {31'd0, o_busy},  32'd0);
        chk("rst_done",  {31'd0, o_done},  32'd0);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_wr",    {31'd0, o_wr},    32'd0);
        chk("rst_rd",    {31'd0, o_rd},    32'd0);
        chk("rst_wdata", {24'd0, o_wdata}, 32'd0);
    endtask

    task automatic begin_txn(input logic [23:0] addr, input logic [7:0] len);
        exp_wq.delete();
        exp_dq.delete();
        wr_cnt = 0; rd_cnt = 0; dlv_cnt = 0; done_cnt = 0; stall_cnt = 0;
        cur_addr = addr;
        exp_wq.push_back(CMD);
        exp_wq.push_back(addr[23:16]);
        exp_wq.push_back(addr[15:8]);
        exp_wq.push_back(addr[7:0]);
        for (int k = 0; k < int'(len); k++) begin
            exp_wq.push_back(DUMMY);
            exp_dq.push_back(loop_mode ? ~DUMMY : flash_byte(addr + 24'(k)));
        end
        i_addr  = addr;
        i_len   = len;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_addr  = 24'($urandom);
        i_len   = 8'($urandom);
    endtask

    task automatic finish_txn(input logic [7:0] len, input bit restart);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20000) begin
            if (restart && n == 3) i_start = 1'b1;
            if (restart && n == 6) i_start = 1'b0;
            step();
            n++;
        end
        i_start = 1'b0;
        if (done_cnt == 0) begin
            i_rst = 1'b1;
            step();
            i_rst = 1'b0;
        end
        repeat (3) step();
        chk("done_cnt", done_cnt, 32'd1);
        chk("wr_cnt", wr_cnt, 32'(len) + 32'd4);
        chk("rd_cnt", rd_cnt, 32'(len) + 32'd4);
        chk("dlv_cnt", dlv_cnt, 32'(len));
        chk("wq_left", exp_wq.size(), 32'd0);
        chk("dq_left", exp_dq.size(), 32'd0);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic run_txn(input logic [23:0] addr, input logic [7:0] len, input bit restart);
        begin_txn(addr, len);
        finish_txn(len, restart);
    endtask

    initial begin
        int n;
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1; i_bsy = 1'b0; i_rdy = 1'b0;
        i_addr = 24'h0; i_len = 8'h0; i_rdata = 8'h0;
        ph_state = 0; ph_cnt = 0; byte_no = 0; ph_data = 8'h00;
        loop_mode = 1'b0; rand_ready = 1'b0; force_on = 1'b0; prev_hold = 1'b0;
        ready_hold = 0; force_cnt = 0; prev_data = 8'h00; cur_addr = 24'h0;
        wr_cnt = 0; rd_cnt = 0; dlv_cnt = 0; done_cnt = 0; stall_cnt = 0;

        // Reset with a start request pending: reset must win.
        i_start = 1'b1;
        repeat (3) step();
        i_rst = 1'b0;
        i_start = 1'b0;
        @(negedge i_clk);
        check_idle_outputs();

        // Header-only read.
        run_txn(24'h123456, 8'd0, 1'b0);

        // Inverted loopback: each data byte returns ~DUMMY.
        loop_mode = 1'b1;
        run_txn(24'($urandom), 8'd2, 1'b0);
        loop_mode = 1'b0;

        // Consumer stalls a delivered byte for ten cycles.
        ready_hold = 10;
        run_txn(24'($urandom), 8'd1, 1'b0);
        chk("stall_cycles", stall_cnt, 32'd10);

        // Phy busy for five cycles as the first byte is due.
        force_cnt = 5;
        run_txn(24'($urandom), 8'd3, 1'b0);

        // Start re-requested while busy is ignored.
        run_txn(24'($urandom), 8'd2, 1'b1);

        // Reset while waiting on the second address byte, then a clean restart.
        begin_txn(24'hABCDEF, 8'd3);
        n = 0;
        while (wr_cnt < 3 && n < 200) begin
            step();
            n++;
        end
        chk("reach_addr1", wr_cnt, 32'd3);
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        @(negedge i_clk);
        check_idle_outputs();
        run_txn(24'($urandom), 8'd2, 1'b0);

        // Randomized traffic with random consumer readiness.
        rand_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            run_txn(24'($urandom), 8'($urandom_range(0, 5)), 1'b0);
        end
        run_txn(24'hFFFFF0, 8'd255, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_rd.md
SPI_FLASH_RD -- requirements
Module: spi_flash_rd

Interface
REQ-001 SHALL have parameter CMD, default 8'h03, the command byte sent first.
REQ-002 SHALL have parameter DUMMY, default 8'h00, the byte written while clocking in data.
REQ-003 SHALL have port i_clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port i_start, input, 1, transaction request; sampled only in IDLE.
REQ-006 SHALL have port i_addr, input, 24, flash byte address.
REQ-007 SHALL have port i_len, input, 8, number of data bytes to read (0..255).
REQ-008 SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-009 SHALL have port o_done, output, 1, one-cycle pulse when a transaction completes.
REQ-010 SHALL have port o_data, output, 8, received data byte.
REQ-011 SHALL have port o_valid, output, 1, o_data is valid.
REQ-012 SHALL have port i_ready, input, 1, consumer accepts o_data.
REQ-013 SHALL have port o_wr, output, 1, byte-write strobe to spi_phy i_wr.
REQ-014 SHALL have port o_wdata, output, 8, byte to spi_phy i_wdata.
REQ-015 SHALL have port i_bsy, input, 1, from spi_phy o_bsy.
REQ-016 SHALL have port o_rd, output, 1, byte-consume strobe to spi_phy i_rd.
REQ-017 SHALL have port i_rdata, input, 8, from spi_phy o_rdata.
REQ-018 SHALL have port i_rdy, input, 1, from spi_phy o_rdy.

Function
REQ-019 SHALL implement states IDLE, SEND, WAIT, DROP, DELIVER.
REQ-020 SHALL, in IDLE with i_start=1, latch i_addr and i_len, clear byte index, and enter SEND on the next cycle.
REQ-021 SHALL ignore i_start in any state other than IDLE.
REQ-022 SHALL send bytes in order: CMD, i_addr[23:16], i_addr[15:8], i_addr[7:0], then DUMMY once per data byte; o_wdata holds the current byte throughout SEND.
REQ-023 SHALL, in SEND, assert o_wr for exactly one cycle, the first cycle where i_bsy=0, then enter WAIT; o_wr stays 0 while i_bsy=1.
REQ-024 SHALL, in WAIT, remain until i_rdy=1, then enter DROP for header bytes (index 0..3) or DELIVER for data bytes.
REQ-025 SHALL, in DROP, assert o_rd for exactly one cycle to discard the received byte, then advance the index.
REQ-026 SHALL, in DELIVER, drive o_valid=1 and o_data=i_rdata, holding both stable until i_ready=1.
REQ-027 SHALL, in the DELIVER cycle with i_ready=1, assert o_rd for that cycle only and decrement the remaining count.
REQ-028 SHALL, after the last byte (the fourth header byte when len=0, else the last data byte), return to IDLE and pulse o_done in the same cycle as that final o_rd.
REQ-029 SHALL, otherwise, return to SEND for the next byte.
REQ-030 SHALL, when i_len=0, issue only the four header writes with no DELIVER.
REQ-031 SHALL never assert o_wr and o_rd in the same cycle, and never assert o_valid outside DELIVER.
REQ-032 SHALL set o_busy = (state != IDLE) combinationally from state.

Reset
REQ-033 SHALL, on i_rst=1 at a clock edge, enter IDLE from any state, including mid-transaction.
REQ-034 SHALL, on reset, clear the latched address, length and index.
REQ-035 SHALL, on the cycle after reset, drive o_busy, o_done, o_valid, o_wr and o_rd to 0 and o_wdata to 8'h00.
REQ-036 SHALL give i_rst priority over i_start in the same cycle.

Verification
REQ-037 SHALL pass: i_start, addr 24'h123456, len 0 -> o_wdata sequence 03,12,34,56, four o_rd pulses, o_valid never high, one o_done.
REQ-038 SHALL pass: with spi_phy looped COPI->CIPO inverted, len 2 and i_ready=1 -> o_data FF then FF, two o_valid handshakes, then o_done.
REQ-039 SHALL pass: len 1 with i_ready held 0 for 10 cycles -> o_valid and o_data stable for 10 cycles, no o_rd and no new o_wr until i_ready=1.
REQ-040 SHALL pass: i_bsy forced 1 for 5 cycles in SEND -> o_wr stays 0, then pulses exactly once after i_bsy falls.
REQ-041 SHALL pass: i_rst asserted in WAIT of the second address byte -> next cycle IDLE with all outputs 0; a new i_start then begins again with CMD.
REQ-042 SHALL pass: i_start re-asserted while o_busy=1 -> ignored, byte count and o_done unchanged.
